pio_button_ctrl: RTL and testbench
==================================

// Module: pio_button_ctrl
// PURPOSE
//  Input-conditioning controller for the push-button/switch PIO feeding the Nios
//  ball/paddle software. Synchronises raw in_port bits, debounces each bit with a
//  per-bit counter FSM, captures rising edges and raises an interrupt, so software
//  stops polling bouncy raw data. Avalon-MM slave with the standard PIO register map.
// PARAMETERS
//  WIDTH            4       number of input bits
//  DEBOUNCE_CYCLES  500000  cycles an input must stay stable before it is accepted (10 ms @ 50 MHz)
//  CNT_W            20      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous active-low reset
//  address    in   2      Avalon word address
//  chipselect in   1      Avalon select
//  write_n    in   1      Avalon write strobe, active-low
//  writedata  in   32     Avalon write data
//  readdata   out  32     Avalon read data, registered
//  in_port    in   WIDTH  raw asynchronous inputs (buttons)
//  irq        out  1      level interrupt to Nios
// BEHAVIOUR
//  Reset: sync FFs, stable, counters, irqmask, edgecapture, readdata all 0; irq 0.
//  Sync: 2-FF synchroniser per bit -> sync[i].
//  Debounce, per bit, 2 states:
//   STABLE: sync==stable -> cnt=0, stay. sync!=stable -> cnt=1, go COUNTING.
//   COUNTING: sync==stable (bounce back) -> cnt=0, go STABLE, no change.
//    sync!=stable & cnt==DEBOUNCE_CYCLES-1 -> stable<=sync, cnt=0, go STABLE.
//    else cnt++.
//   Latency: in_port change held steady -> stable updates 2+DEBOUNCE_CYCLES cycles later.
//   A glitch shorter than DEBOUNCE_CYCLES never reaches stable.
//   Counter never wraps; saturation is impossible by construction.
//  Edge capture: stable[i] 0->1 sets edgecapture[i] in the same cycle stable updates.
//   Falling edges are ignored.
//  Register map (32-bit, unused upper bits read 0):
//   0 DATA        RO   stable[WIDTH-1:0]; writes ignored
//   1 reserved    RO   reads 0
//   2 IRQMASK     RW   bit i enables edgecapture[i] into irq
//   3 EDGECAPTURE R/W1C  write clears bits where writedata[i]=1
//  Write accepted when chipselect & !write_n.
//  Same-cycle set and W1C of one bit -> bit ends set (set wins).
//  readdata <= mux(address) every clock: one-cycle read latency, zero-extended.
//  irq = |(edgecapture & irqmask), driven from registers (no combinational path
//   from Avalon inputs). Held until software clears the edge or the mask.
//  Reset mid-debounce: counter and state discarded. stable returns 0. Pending edges lost.
// TESTING (bench uses DEBOUNCE_CYCLES=8)
//  1 Reset: reset_n=0 with in_port=4'hF -> readdata=0, irq=0. Release: DATA reads
//    0x0 until cycle 10, then reads 0xF.
//  2 Bounce: bit0 toggles 1/0 every 3 cycles for 30 cycles, then stays 1 ->
//    stable[0] rises exactly 10 cycles after the last toggle. EDGECAPTURE=0x1.
//  3 IRQ: write IRQMASK=0x1, press bit0 -> irq=1.
//    Write EDGECAPTURE=0x1 -> irq=0 the next cycle.
//    Press bit1 with mask 0x1 -> edgecapture=0x2, irq stays 0.
//  4 Collision: W1C of bit2 in the same cycle stable[2] rises -> EDGECAPTURE bit2=1.
//  5 Release: debounced 1->0 on bit3 -> DATA bit3=0, EDGECAPTURE unchanged, irq unchanged.
//  6 Reset mid-count: assert reset_n at cnt=5 -> all registers 0.
//    After release with input still high, the full 10-cycle latency is seen again.

Source files
------------

// File: rtl/pio_button_ctrl.sv
// pio_button_ctrl: input conditioning for the button/switch PIO.
// Each raw input bit is synchronised, debounced by its own counter FSM, and
// its debounced rising edges are latched in EDGECAPTURE, which can raise irq.
// Software sees a standard PIO register map over Avalon-MM. Reads have one cycle
// of latency.
// DEBOUNCE_CYCLES must be at least 2, and 2**CNT_W must be greater than DEBOUNCE_CYCLES.
module pio_button_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync;

    db_state_t        state      [WIDTH];
    db_state_t        state_next [WIDTH];
    logic [CNT_W-1:0] cnt        [WIDTH];
    logic [CNT_W-1:0] cnt_next   [WIDTH];
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;

    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clear;
    logic             wr;
    logic [31:0]      rd_mux;

    // Only the low WIDTH bits of writedata matter. The upper bits are deliberately ignored.
    logic unused_writedata;
    assign unused_writedata = &{1'b0, writedata[31:WIDTH]};

    // Two-flop synchroniser that brings the asynchronous button inputs into the clk domain.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= in_port;
            sync      <= sync_meta;
        end
    end

    // Debounce state registers. A reset throws away any count that is in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= ST_STABLE;
                cnt[i]   <= '0;
            end
            stable <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
            stable <= stable_next;
        end
    end

    // Per-bit debounce FSM. A new level is accepted only after DEBOUNCE_CYCLES identical samples.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < WIDTH; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            unique case (state[i])
                ST_STABLE: begin
                    if (sync[i] != stable[i]) begin
                        cnt_next[i]   = CNT_ONE;
                        state_next[i] = ST_COUNTING;
                    end else begin
                        cnt_next[i] = '0;
                    end
                end
                ST_COUNTING: begin
                    if (sync[i] == stable[i]) begin
                        // The input bounced back before it was accepted.
                        cnt_next[i]   = '0;
                        state_next[i] = ST_STABLE;
                    end else if (cnt[i] == CNT_LAST) begin
                        stable_next[i] = sync[i];
                        cnt_next[i]    = '0;
                        state_next[i]  = ST_STABLE;
                    end else begin
                        cnt_next[i] = cnt[i] + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign wr    = chipselect & ~write_n;
    // A debounced rising edge is detected in the same cycle that stable updates.
    assign rise  = stable_next & ~stable;
    assign clear = (wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    // Software registers. When a set and a write-1-to-clear hit one bit together, the set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr && (address == ADDR_IRQMASK)) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecapture <= (edgecapture & ~clear) | rise;
        end
    end

    // Read mux. Unused and reserved bits read as zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
            default:      rd_mux = '0;
        endcase
    end

    // Registered read data, giving a fixed one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    // irq depends only on registers, so no Avalon input can reach it combinationally.
    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pio_button_ctrl.sv
// Testbench for pio_button_ctrl with a short debounce window (8 cycles).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pio_button_ctrl;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    pio_button_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model. A bit is accepted once the last D synchronised samples
    // all disagree with the current debounced value. Samples lag in_port by two clocks.
    logic [W-1:0] m_pipe0, m_pipe1, m_obs, m_stable, m_new, m_ec, m_mask, m_clr;
    logic [D-1:0] m_win [W];
    logic [31:0]  m_rd;

    task automatic model_step();
        if (!reset_n) begin
            m_pipe0 = '0; m_pipe1 = '0; m_stable = '0; m_ec = '0; m_mask = '0; m_rd = '0;
            for (int i = 0; i < W; i++) m_win[i] = '0;
        end else begin
            m_rd = '0;
            if (address == 2'd0) m_rd[W-1:0] = m_stable;
            if (address == 2'd2) m_rd[W-1:0] = m_mask;
            if (address == 2'd3) m_rd[W-1:0] = m_ec;
            m_obs   = m_pipe1;
            m_pipe1 = m_pipe0;
            m_pipe0 = in_port;
            m_new   = m_stable;
            for (int i = 0; i < W; i++) begin
                m_win[i] = {m_win[i][D-2:0], m_obs[i]};
                if (m_win[i] == {D{~m_stable[i]}}) m_new[i] = ~m_stable[i];
            end
            m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            m_ec  = (m_ec & ~m_clr) | (m_new & ~m_stable);
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            m_stable = m_new;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [W-1:0] in_val);
        reset_n = 1'b0; in_port = in_val; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = '0;
        ticks(2);
        reset_n = 1'b1;
    endtask

    task automatic avalon_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    typedef struct {
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [14];

    initial begin
        // Register-access vectors, applied after a reset with idle inputs.
        // exp_rd is the value read at the address presented on that edge, before that edge's write.
        vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_000F, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'd2, 32'h0,         32'hF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFF5, 32'hF, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h5, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 32'h0000_000F, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'd0, 32'h0,         32'h0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'd1, 32'h0,         32'h0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'd3, 32'h0000_000F, 32'h0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'd3, 32'h0,         32'h0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'd2, 32'h0,         32'h5, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h5, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h5, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 2'd3, 32'h0,         32'h0, 1'b0};

        // Test 1: reset state, then the 10-cycle acceptance latency seen through the read port.
        reset_n = 1'b0; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = '0;
        ticks(3);
        check("t1_reset_readdata", readdata, 32'h0);
        check("t1_reset_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            // stable flips on edge 10, and the registered read shows it one edge later.
            check($sformatf("t1_data_k%0d", k), readdata, (k >= 11) ? 32'hF : 32'h0);
        end

        // Test 2: bounce on bit 0 is rejected. The final level is accepted 10 cycles after the last toggle.
        do_reset('0);
        ticks(3);
        for (int seg = 0; seg < 10; seg++) begin
            in_port = (seg % 2 == 0) ? 4'h1 : 4'h0;
            for (int j = 0; j < 3; j++) begin
                tick();
                check("t2_bounce_data", readdata, 32'h0);
            end
        end
        in_port = 4'h1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            check($sformatf("t2_settle_k%0d", k), readdata, (k == 11) ? 32'h1 : 32'h0);
        end
        address = 2'd3;
        tick();
        check("t2_edgecapture", readdata, 32'h1);
        check("t2_irq_masked", {31'd0, irq}, 32'h0);

        // Test 3: irq follows edgecapture & mask, and W1C drops it on the next edge.
        do_reset('0);
        ticks(3);
        avalon_write(2'd2, 32'h1);
        in_port = 4'h1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("t3_irq_k%0d", k), {31'd0, irq}, (k == 10) ? 32'h1 : 32'h0);
        end
        avalon_write(2'd3, 32'h1);
        check("t3_irq_after_w1c", {31'd0, irq}, 32'h0);
        in_port = 4'h3;
        ticks(10);
        address = 2'd3;
        tick();
        check("t3_edgecapture_bit1", readdata, 32'h2);
        check("t3_irq_masked", {31'd0, irq}, 32'h0);

        // Test 4: a W1C of bit 2 in the same cycle that bit 2 is set leaves bit 2 set.
        in_port = 4'h7;
        ticks(9);
        avalon_write(2'd3, 32'h4);
        address = 2'd3;
        tick();
        check("t4_collision", readdata, 32'h6);
        check("t4_irq", {31'd0, irq}, 32'h0);

        // Test 5: a debounced falling edge changes DATA only.
        in_port = 4'hF;
        ticks(10);
        avalon_write(2'd2, 32'h8);
        check("t5_irq_before", {31'd0, irq}, 32'h1);
        in_port = 4'h7;
        address = 2'd0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k >= 10) check($sformatf("t5_data_k%0d", k), readdata, (k == 11) ? 32'h7 : 32'hF);
        end
        check("t5_irq_after", {31'd0, irq}, 32'h1);
        address = 2'd3;
        tick();
        check("t5_edgecapture", readdata, 32'hE);

        // Test 6: reset in mid-count (cnt=5) clears everything, and the full latency is seen again.
        in_port = 4'hF;
        address = 2'd0;
        ticks(7);
        reset_n = 1'b0;
        #1;
        check("t6_async_readdata", readdata, 32'h0);
        check("t6_async_irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        ticks(2);
        reset_n = 1'b1;
        address = 2'd2;
        tick();
        check("t6_irqmask", readdata, 32'h0);
        address = 2'd3;
        tick();
        check("t6_edgecapture", readdata, 32'h0);
        address = 2'd0;
        for (int k = 3; k <= 12; k++) begin
            tick();
            check($sformatf("t6_data_k%0d", k), readdata, (k >= 11) ? 32'hF : 32'h0);
        end
        check("t6_irq", {31'd0, irq}, 32'h0);

        // Table-driven register access.
        do_reset('0);
        ticks(3);
        for (int v = 0; v < 14; v++) begin
            chipselect = vecs[v].cs; write_n = vecs[v].wn;
            address = vecs[v].addr; writedata = vecs[v].wd;
            tick();
            check($sformatf("vec%0d_readdata", v), readdata, vecs[v].exp_rd);
            check($sformatf("vec%0d_irq", v), {31'd0, irq}, {31'd0, vecs[v].exp_irq});
        end
        chipselect = 1'b0; write_n = 1'b1;

        // Random stimulus compared against the reference model every cycle.
        do_reset('0);
        ticks(3);
        for (int n = 0; n < 4000; n++) begin
            check("rand_readdata", readdata, m_rd);
            check("rand_irq", {31'd0, irq}, {31'd0, |(m_ec & m_mask)});
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 23) == 0) in_port[b] = ~in_port[b];
            end
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            if (n == 2000) reset_n = 1'b0;
            if (n == 2002) reset_n = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
